// File: rtl/regfile_arbiter_if.sv
// Client/register-file bundle for the two-client register file arbiter.
// The arbiter is the slave of the clients; the register file and the clients see the master side.
interface regfile_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 2
) ();
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          done0, done1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] rf_s;
  logic [DW-1:0] rf_d;
  logic          rf_we;
  logic [DW-1:0] rf_q;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_q,
    output gnt0, gnt1, done0, done1, rdata, busy, rf_s, rf_d, rf_we
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rf_q,
    input  gnt0, gnt1, done0, done1, rdata, busy, rf_s, rf_d, rf_we
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter serialising two clients' read/write requests onto the 4 x 8 register file port.
// Each transaction walks IDLE -> ACC -> RESP; the register file port is driven only from latched state.
module regfile_arbiter #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t        state, state_nx;
  logic          start;
  logic          pick;
  logic          sel;
  logic          last;
  logic          we_l;
  logic [AW-1:0] addr_l;
  logic [DW-1:0] wdata_l;
  logic [DW-1:0] rdata_r;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    pick      = 1'b0;
    bus.gnt0  = 1'b0;
    bus.gnt1  = 1'b0;
    bus.done0 = 1'b0;
    bus.done1 = 1'b0;
    bus.rf_we = 1'b0;
    bus.busy  = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          start    = 1'b1;
          state_nx = ACC;
          // On a tie the client that did not win last time goes first.
          pick     = (bus.req0 && bus.req1) ? ~last : bus.req1;
        end
      end
      ACC: begin
        state_nx  = RESP;
        bus.gnt0  = ~sel;
        bus.gnt1  = sel;
        bus.rf_we = we_l;
      end
      RESP: begin
        state_nx  = IDLE;
        bus.done0 = ~sel;
        bus.done1 = sel;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: these are plain control/data registers, so all of them get a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= 1'b0;
      last    <= 1'b1;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata_r <= '0;
    end else begin
      if (start) begin
        sel     <= pick;
        last    <= pick;
        we_l    <= pick ? bus.we1    : bus.we0;
        addr_l  <= pick ? bus.addr1  : bus.addr0;
        wdata_l <= pick ? bus.wdata1 : bus.wdata0;
      end
      // Read data is captured at the edge ending ACC, while rf_s still points at the target.
      if (state == ACC && !we_l) rdata_r <= bus.rf_q;
    end
  end

  assign bus.rf_s  = addr_l;
  assign bus.rf_d  = wdata_l;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: emulated register file, transaction-level model,
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
module tb_regfile_arbiter;

  logic clk;
  logic rst;

  regfile_arbiter_if #(.DW(8), .AW(2)) bus ();

  regfile_arbiter #(.DW(8), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated register file: combinational read, write on the edge ending a strobe cycle.
  logic [7:0] mem [4];
  assign bus.rf_q = mem[bus.rf_s];
  always @(posedge clk) if (bus.rf_we) mem[bus.rf_s] <= bus.rf_d;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic       g0, g1, d0, d1, busy, we;
    logic [1:0] s;
    logic [7:0] d;
    logic [7:0] q;
    logic       cw, rd;
    logic [1:0] ca;
    logic [7:0] cd;
  } exp_t;

  exp_t       cur = '0;
  exp_t       sched [$];
  logic [7:0] gold [4];
  int         m_last = 1;

  // At each edge decide what the coming cycle must look like: either the next scheduled
  // cycle of an accepted transaction, a freshly accepted one, or an idle cycle.
  always @(posedge clk or posedge rst) begin
    exp_t acc, resp;
    int   s;
    if (rst) begin
      sched.delete();
      m_last = 1;
      cur    = '0;
    end else if (sched.size() != 0) begin
      cur = sched.pop_front();
      if (cur.cw) gold[cur.ca] = cur.cd;
      if (cur.rd) cur.q = gold[cur.ca];
    end else if (!cur.busy && (bus.req0 || bus.req1)) begin
      s      = (bus.req0 && bus.req1) ? 1 - m_last : (bus.req1 ? 1 : 0);
      m_last = s;
      acc      = cur;
      acc.g0   = (s == 0);
      acc.g1   = (s == 1);
      acc.d0   = 1'b0;
      acc.d1   = 1'b0;
      acc.busy = 1'b1;
      acc.we   = s ? bus.we1 : bus.we0;
      acc.s    = s ? bus.addr1 : bus.addr0;
      acc.d    = s ? bus.wdata1 : bus.wdata0;
      acc.cw   = 1'b0;
      acc.rd   = 1'b0;
      resp     = acc;
      resp.g0  = 1'b0;
      resp.g1  = 1'b0;
      resp.d0  = (s == 0);
      resp.d1  = (s == 1);
      resp.we  = 1'b0;
      resp.cw  = acc.we;
      resp.rd  = !acc.we;
      resp.ca  = acc.s;
      resp.cd  = acc.d;
      sched.push_back(resp);
      cur = acc;
    end else begin
      cur.g0   = 1'b0;
      cur.g1   = 1'b0;
      cur.d0   = 1'b0;
      cur.d1   = 1'b0;
      cur.busy = 1'b0;
      cur.we   = 1'b0;
      cur.cw   = 1'b0;
      cur.rd   = 1'b0;
    end
  end

  // Compare process: every cycle outside reset, all outputs against the model.
  always @(negedge clk) begin
    if (!rst)
      check("cycle",
            32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.rf_we,
                 bus.rf_s, bus.rf_d, bus.rdata}),
            32'({cur.g0, cur.g1, cur.d0, cur.d1, cur.busy, cur.we, cur.s, cur.d, cur.q}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input int c, input logic w, input logic [1:0] a, input logic [7:0] d);
    if (c == 0) begin
      bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic drop_req(input int c);
    if (c == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i]  = 8'h00;
      gold[i] = 8'h00;
    end
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 2'd0; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 2'd0; bus.wdata1 = 8'h00;
    rst = 1'b0;
    #1 rst = 1'b1;
    tick(); tick();
    check("reset_busy",  32'(bus.busy),  32'd0);
    check("reset_rf_we", 32'(bus.rf_we), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;
    tick();

    // Single write from client 0.
    drive_req(0, 1'b1, 2'd2, 8'hA5);
    tick();
    check("wr_gnt0",  32'(bus.gnt0),  32'd1);
    check("wr_rf_s",  32'(bus.rf_s),  32'd2);
    check("wr_rf_d",  32'(bus.rf_d),  32'hA5);
    check("wr_rf_we", 32'(bus.rf_we), 32'd1);
    drop_req(0);
    tick();
    check("wr_done0", 32'(bus.done0), 32'd1);
    check("wr_we_off", 32'(bus.rf_we), 32'd0);
    tick();

    // Read-back from client 1.
    drive_req(1, 1'b0, 2'd2, 8'h00);
    tick();
    check("rd_gnt1",  32'(bus.gnt1),  32'd1);
    check("rd_rf_we", 32'(bus.rf_we), 32'd0);
    drop_req(1);
    tick();
    check("rd_done1", 32'(bus.done1), 32'd1);
    check("rd_rdata", 32'(bus.rdata), 32'hA5);
    tick();

    // Tie: client 0 first (cycle 1), client 1 at cycle 4.
    drive_req(0, 1'b1, 2'd0, 8'h11);
    drive_req(1, 1'b1, 2'd1, 8'h22);
    tick();
    check("tie_c1_gnt0", 32'(bus.gnt0), 32'd1);
    check("tie_c1_gnt1", 32'(bus.gnt1), 32'd0);
    drop_req(0);
    tick(); tick();
    check("tie_c3_busy", 32'(bus.busy), 32'd0);
    tick();
    check("tie_c4_gnt1", 32'(bus.gnt1), 32'd1);
    drop_req(1);
    tick(); tick();
    check("tie_reg0", 32'(mem[0]), 32'h11);
    check("tie_reg1", 32'(mem[1]), 32'h22);

    // Fairness: both held high for 12 cycles.
    drive_req(0, 1'b0, 2'd0, 8'h00);
    drive_req(1, 1'b0, 2'd1, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("fair_gnt0_%0d", i), 32'(bus.gnt0), 32'((i % 6) == 1));
      check($sformatf("fair_gnt1_%0d", i), 32'(bus.gnt1), 32'((i % 6) == 4));
    end
    drop_req(0);
    drop_req(1);
    tick(); tick();

    // All addresses: writes via client 1, reads via client 0.
    for (int i = 0; i < 4; i++) begin
      drive_req(1, 1'b1, 2'(i), 8'(8'h10 + i));
      tick(); drop_req(1);
      tick(); tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 1'b0, 2'(i), 8'h00);
      tick(); drop_req(0);
      tick();
      check($sformatf("all_done0_%0d", i), 32'(bus.done0), 32'd1);
      check($sformatf("all_rdata_%0d", i), 32'(bus.rdata), 32'(8'h10 + i));
      tick();
    end

    // Reset in the ACC cycle of a write.
    drive_req(0, 1'b1, 2'd3, 8'hFF);
    tick();
    check("rst_acc_we", 32'(bus.rf_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_we_drop", 32'(bus.rf_we), 32'd0);
    check("rst_busy",    32'(bus.busy),  32'd0);
    check("rst_gnt0",    32'(bus.gnt0),  32'd0);
    drop_req(0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_no_done0_%0d", i), 32'(bus.done0), 32'd0);
    end
    check("rst_reg3", 32'(mem[3]), 32'h13);
    drive_req(0, 1'b0, 2'd0, 8'h00);
    drive_req(1, 1'b0, 2'd1, 8'h00);
    tick();
    check("rst_tie_gnt0", 32'(bus.gnt0), 32'd1);
    check("rst_tie_gnt1", 32'(bus.gnt1), 32'd0);
    drop_req(0);

    // Random traffic: clients drop req on grant and raise new ones at random.
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.req0 && bus.gnt0) drop_req(0);
      else if (!bus.req0 && $urandom_range(3) == 0)
        drive_req(0, 1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)));
      if (bus.req1 && bus.gnt1) drop_req(1);
      else if (!bus.req1 && $urandom_range(3) == 0)
        drive_req(1, 1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)));
    end
    drop_req(0);
    drop_req(1);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("final_reg%0d", i), 32'(mem[i]), 32'(gold[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
